// File: rtl/line_encoder.sv
// Serialises wiring words (light patterns, button index lists, line/file markers)
// into an ASCII byte stream with a valid/ready handshake on both sides.
module line_encoder #(
  parameter int unsigned MAX_WIRING_WIDTH = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wiring_valid,
  output logic                                  wiring_ready,
  input  logic [1:0]                            wiring_kind,
  input  logic [MAX_WIRING_WIDTH-1:0]           wiring_data,
  input  logic [$clog2(MAX_WIRING_WIDTH):0]     wiring_len,
  output logic                                  outbound_valid,
  input  logic                                  outbound_ready,
  output logic [7:0]                            outbound_byte,
  output logic                                  end_of_file
);

  localparam int unsigned W  = MAX_WIRING_WIDTH;
  localparam int unsigned LW = $clog2(MAX_WIRING_WIDTH) + 1;

  typedef enum logic [3:0] {
    IDLE, LIGHT_OPEN, LIGHT_BITS, LIGHT_CLOSE,
    BTN_SPACE, BTN_OPEN, BTN_DIGIT, BTN_COMMA, BTN_CLOSE,
    EMIT_LF, EMIT_NUL, DONE
  } state_t;

  state_t         r_state, nx_state;
  logic [W-1:0]   r_data, nx_data;
  logic [LW-1:0]  r_len, nx_len;
  logic [LW-1:0]  r_idx, nx_idx;
  logic [7:0]     r_byte, nx_byte;
  logic           r_valid, nx_valid;
  logic           r_ready, nx_ready;
  logic           r_eof, nx_eof;

  logic           w_accept;
  logic           w_consume;
  logic [LW-1:0]  w_len_clamp;
  logic [W-1:0]   w_shift;
  logic [W-1:0]   w_cleared;
  logic [LW-1:0]  w_low;
  logic [7:0]     w_digit;
  logic [LW-1:0]  w_idx_inc;

  // Index of the lowest set bit of the working copy (0 when empty).
  function automatic logic [LW-1:0] lowest_set(input logic [W-1:0] d);
    lowest_set = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (d[i]) lowest_set = LW'(i);
    end
  endfunction

  assign w_accept    = wiring_valid && r_ready;
  assign w_consume   = r_valid && outbound_ready;
  assign w_len_clamp = (wiring_len > LW'(W)) ? LW'(W) : wiring_len;
  assign w_shift     = r_data >> 1;
  assign w_cleared   = r_data & ~(W'(1) << r_idx);
  assign w_low       = lowest_set(r_data);
  assign w_digit     = 8'h30 + 8'(w_low);
  assign w_idx_inc   = r_idx + LW'(1);

  always_comb begin
    nx_state = r_state;
    nx_data  = r_data;
    nx_len   = r_len;
    nx_idx   = r_idx;
    nx_byte  = r_byte;
    nx_eof   = r_eof;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          nx_data = wiring_data;
          nx_len  = w_len_clamp;
          nx_idx  = '0;
          case (wiring_kind)
            2'd0:    begin nx_state = LIGHT_OPEN; nx_byte = 8'h5B; end
            2'd1:    begin nx_state = BTN_SPACE;  nx_byte = 8'h20; end
            2'd2:    begin nx_state = EMIT_LF;    nx_byte = 8'h0A; end
            default: begin nx_state = EMIT_NUL;   nx_byte = 8'h00; end
          endcase
        end
      end
      LIGHT_OPEN: begin
        if (w_consume) begin
          if (r_len == '0) begin
            nx_state = LIGHT_CLOSE;
            nx_byte  = 8'h5D;
          end else begin
            nx_state = LIGHT_BITS;
            nx_byte  = r_data[0] ? 8'h23 : 8'h2E;
          end
        end
      end
      // Light data shifts right so the current character is always bit 0.
      LIGHT_BITS: begin
        if (w_consume) begin
          nx_idx  = w_idx_inc;
          nx_data = w_shift;
          if (w_idx_inc == r_len) begin
            nx_state = LIGHT_CLOSE;
            nx_byte  = 8'h5D;
          end else begin
            nx_byte  = w_shift[0] ? 8'h23 : 8'h2E;
          end
        end
      end
      LIGHT_CLOSE, BTN_CLOSE, EMIT_LF: begin
        if (w_consume) nx_state = IDLE;
      end
      BTN_SPACE: begin
        if (w_consume) begin
          nx_state = BTN_OPEN;
          nx_byte  = 8'h28;
        end
      end
      BTN_OPEN, BTN_COMMA: begin
        if (w_consume) begin
          if (r_data == '0) begin
            nx_state = BTN_CLOSE;
            nx_byte  = 8'h29;
          end else begin
            nx_state = BTN_DIGIT;
            nx_idx   = w_low;
            nx_byte  = w_digit;
          end
        end
      end
      // Drop the digit just emitted; a comma follows only if bits remain.
      BTN_DIGIT: begin
        if (w_consume) begin
          nx_data = w_cleared;
          if (w_cleared != '0) begin
            nx_state = BTN_COMMA;
            nx_byte  = 8'h2C;
          end else begin
            nx_state = BTN_CLOSE;
            nx_byte  = 8'h29;
          end
        end
      end
      EMIT_NUL: begin
        if (w_consume) begin
          nx_state = DONE;
          nx_eof   = 1'b1;
        end
      end
      default: begin
        nx_state = r_state;
      end
    endcase

    nx_valid = (nx_state != IDLE) && (nx_state != DONE);
    nx_ready = (nx_state == IDLE) && !nx_eof;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_byte  <= 8'h00;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_state <= nx_state;
      r_data  <= nx_data;
      r_len   <= nx_len;
      r_idx   <= nx_idx;
      r_byte  <= nx_byte;
      r_valid <= nx_valid;
      r_ready <= nx_ready;
      r_eof   <= nx_eof;
    end
  end

  assign wiring_ready   = r_ready;
  assign outbound_valid = r_valid;
  assign outbound_byte  = r_byte;
  assign end_of_file    = r_eof;

endmodule

// File: tb/tb_line_encoder.sv
// Scoreboard bench for line_encoder: directed words push hand-computed bytes,
// a negedge monitor pops and compares every transferred byte.
module tb_line_encoder;

  localparam int unsigned W  = 10;
  localparam int unsigned LW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wiring_valid;
  logic          wiring_ready;
  logic [1:0]    wiring_kind;
  logic [W-1:0]  wiring_data;
  logic [LW-1:0] wiring_len;
  logic          outbound_valid;
  logic          outbound_ready;
  logic [7:0]    outbound_byte;
  logic          end_of_file;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte;
  logic [7:0] mon_exp;

  line_encoder #(.MAX_WIRING_WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .wiring_valid   (wiring_valid),
    .wiring_ready   (wiring_ready),
    .wiring_kind    (wiring_kind),
    .wiring_data    (wiring_data),
    .wiring_len     (wiring_len),
    .outbound_valid (outbound_valid),
    .outbound_ready (outbound_ready),
    .outbound_byte  (outbound_byte),
    .end_of_file    (end_of_file)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each transferred byte and verifies stalled bytes hold.
  always @(negedge clk) begin
    if (hold_pend) begin
      check("stall_valid", 32'(outbound_valid), 32'd1);
      check("stall_byte", 32'(outbound_byte), 32'(hold_byte));
    end
    hold_pend = 1'b0;
    if (outbound_valid && outbound_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %02h required none", outbound_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_byte", 32'(outbound_byte), 32'(mon_exp));
      end
    end else if (outbound_valid) begin
      hold_pend = 1'b1;
      hold_byte = outbound_byte;
    end
  end

  task automatic push(input logic [127:0] v, input int n);
    logic [127:0] t;
    for (int k = 0; k < n; k++) begin
      t = v >> (8 * (n - 1 - k));
      exp_q.push_back(t[7:0]);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after acceptance.
  task automatic send(input logic [1:0] kind, input logic [W-1:0] data, input logic [LW-1:0] len);
    int n;
    wiring_kind  = kind;
    wiring_data  = data;
    wiring_len   = len;
    wiring_valid = 1'b1;
    n = 0;
    while (!wiring_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wiring_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 required ready=1");
      wiring_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    wiring_valid = 1'b0;
    wiring_data  = W'($urandom);
    wiring_kind  = 2'($urandom);
    wiring_len   = LW'($urandom);
  endtask

  // Applies a ready pattern (bit c for cycle c, then 1) until the scoreboard empties.
  task automatic drain(input int plen, input logic [7:0] pat, input int exp_cycles);
    int c;
    for (c = 0; c < 64; c++) begin
      outbound_ready = (c < plen) ? pat[3'(c)] : 1'b1;
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes left required 0", exp_q.size());
      exp_q.delete();
    end else if (exp_cycles > 0) begin
      check("byte_cycles", 32'(c + 1), 32'(exp_cycles));
    end
    outbound_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst            = 1'b1;
    wiring_valid   = 1'b0;
    wiring_kind    = 2'd0;
    wiring_data    = '0;
    wiring_len     = '0;
    outbound_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(outbound_valid), 32'd0);
    check("rst_ready", 32'(wiring_ready), 32'd0);
    check("rst_eof", 32'(end_of_file), 32'd0);
    check("rst_byte", 32'(outbound_byte), 32'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'(wiring_ready), 32'd1);
    @(posedge clk); #1;

    push(128'h5B2E23232E5D, 6);
    send(2'd0, 10'b0110, 5'd4);
    drain(0, 8'h00, 6);

    push(128'h2028312C3329, 6);
    send(2'd1, 10'b1010, 5'd0);
    drain(0, 8'h00, 6);

    push(128'h202829, 3);
    send(2'd1, 10'b0, 5'd0);
    drain(0, 8'h00, 3);

    push(128'h5B5D, 2);
    send(2'd0, 10'b1111111111, 5'd0);
    drain(0, 8'h00, 2);

    push(128'h2028302C3329, 6);
    send(2'd1, 10'b1001, 5'd0);
    drain(4, 8'b0000_1001, 8);

    push(128'h5B2E2E2E2E2E23232323235D, 12);
    send(2'd0, 10'b1111100000, 5'd15);
    drain(0, 8'h00, 12);

    // Reset during the third byte of a LIGHT word.
    push(128'h5B2E23, 3);
    send(2'd0, 10'b0110, 5'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(outbound_valid), 32'd0);
    check("midrst_byte", 32'(outbound_byte), 32'h00);
    check("midrst_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("midrst_ready", 32'(wiring_ready), 32'd1);
    @(posedge clk); #1;

    push(128'h2028302C3229, 6);
    send(2'd1, 10'b0101, 5'd0);
    drain(0, 8'h00, 6);

    // Full line ending in end-of-file.
    push(128'h5B2E23232E5D, 6);
    send(2'd0, 10'b0110, 5'd4);
    drain(0, 8'h00, 6);
    push(128'h20283329, 4);
    send(2'd1, 10'b1000, 5'd0);
    drain(0, 8'h00, 4);
    push(128'h2028312C3329, 6);
    send(2'd1, 10'b1010, 5'd0);
    drain(0, 8'h00, 6);
    push(128'h0A, 1);
    send(2'd2, 10'b0, 5'd0);
    drain(0, 8'h00, 1);
    push(128'h00, 1);
    send(2'd3, 10'b0, 5'd0);
    @(negedge clk); #1;
    check("nul_taken", 32'(exp_q.size()), 32'd0);
    check("eof_before", 32'(end_of_file), 32'd0);
    @(negedge clk);
    check("eof_after", 32'(end_of_file), 32'd1);
    check("done_ready", 32'(wiring_ready), 32'd0);
    check("done_valid", 32'(outbound_valid), 32'd0);

    @(posedge clk); #1;
    wiring_valid = 1'b1;
    wiring_kind  = 2'd1;
    wiring_data  = 10'b0011;
    repeat (4) begin
      @(negedge clk);
      check("done_hold_ready", 32'(wiring_ready), 32'd0);
      check("done_hold_valid", 32'(outbound_valid), 32'd0);
    end
    wiring_valid = 1'b0;
    @(negedge clk);
    check("eof_held", 32'(end_of_file), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
